fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the integrated datapath/controller.
- Owns the program counter and reads instruction memory over a request/acknowledge handshake.
- Presents a stable 18-bit instruction on inst for the controller.
- Advances or jumps the PC when the controller asserts PC_inc, with JAddrSelect choosing the jump target.

Parameters:
- ADDR_W, 16, width of PC and instruction-memory address.
- INST_W, 18, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- CLR  input  1  synchronous active-high reset.
- PC_inc  input  1  controller: current instruction retired, advance PC.
- JAddrSelect  input  1  qualifies PC_inc: next PC = jump_target instead of PC+1.
- jump_target  input  ADDR_W  jump/branch address from the register file mux.
- mem_addr  output  ADDR_W  instruction-memory address.
- mem_rd  output  1  read request, held until mem_ack.
- mem_ack  input  1  memory: mem_rdata valid this cycle.
- mem_rdata  input  INST_W  instruction word from memory.
- inst  output  INST_W  instruction to controller/decoder.
- inst_valid  output  1  inst holds the instruction at pc.
- pc  output  ADDR_W  address of the instruction in inst.
- pc_plus1  output  ADDR_W  pc+1 (link value), combinational.
- fetch_err  output  1  sticky: PC_inc seen while not in READY.

Behaviour:
- CLK is the single clock. CLR is synchronous and active-high, sampled on the rising edge of CLK; it overrides every other input.
- Reset values: pc=RESET_PC, inst=NOP (18'h00000), inst_valid=0, mem_rd=0, mem_addr=RESET_PC, fetch_err=0, state=IDLE.
- State machine: IDLE, REQ, READY.
- IDLE: one cycle after reset release, go to REQ with mem_rd=1 and mem_addr=pc.
- REQ:
  - mem_rd=1 and mem_addr=pc held constant until mem_ack.
  - On mem_ack: inst<=mem_rdata, inst_valid<=1, mem_rd<=0, go to READY.
  - Minimum latency: mem_ack in the first REQ cycle gives inst_valid in the next cycle.
  - inst keeps its previous value while in REQ; inst_valid=0.
- READY:
  - inst, pc and inst_valid are stable.
  - On PC_inc=1: pc<=JAddrSelect ? jump_target : pc+1. Then inst_valid<=0, mem_rd<=1, mem_addr<=new pc, go to REQ.
  - Without PC_inc: remain in READY; JAddrSelect alone is ignored.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000. pc_plus1 wraps identically.
- jump_target is sampled only in the cycle PC_inc=1 in READY.
- PC_inc while in IDLE or REQ:
  - Ignored: no PC change, no extra request.
  - fetch_err<=1, cleared only by CLR.
- mem_ack outside REQ is ignored; inst is unchanged.
- CLR mid-fetch (REQ) abandons the request: mem_rd drops on that edge, all reset values apply, and a late mem_ack after reset in IDLE is ignored.
- CLR together with PC_inc: CLR wins and pc=RESET_PC.
- Exactly one outstanding request at a time; no prefetch.

Decomposition:
- Shared package (cpu_pkg):
  - State encoding IDLE/REQ/READY.
  - NOP_INST=18'h00000.
  - Default RESET_PC.
  - INST_W and ADDR_W constants, shared with the decoder and controller.
- Sub-module pc_next: combinational. Inputs pc, jump_target, JAddrSelect; outputs next_pc and pc_plus1. It is the single place for the wrap rule.
- FSM and registers stay in fetch_unit.

Test Plan:
- Reset, then mem_ack one cycle after mem_rd with mem_rdata=18'h12345 -> mem_addr=16'h0000 during REQ; the next cycle gives inst=18'h12345, inst_valid=1, pc=16'h0000, pc_plus1=16'h0001.
- In READY at pc=16'h0004, PC_inc=1, JAddrSelect=0 -> pc=16'h0005, inst_valid=0, mem_rd=1, mem_addr=16'h0005. A mem_ack after 3 wait cycles gives inst_valid=1 exactly one cycle after the ack.
- In READY, PC_inc=1, JAddrSelect=1, jump_target=16'h0200 -> pc=16'h0200, mem_addr=16'h0200. JAddrSelect=1 alone with PC_inc=0 -> no change.
- Force pc=16'hFFFF via jump, then PC_inc with JAddrSelect=0 -> pc=16'h0000. pc_plus1 reads 16'h0000 while pc=16'hFFFF.
- PC_inc pulsed during REQ -> pc unchanged, a single request only, fetch_err=1 and stays 1 until CLR.
- CLR asserted in REQ, then mem_ack arrives one cycle after CLR releases -> inst=18'h00000, inst_valid=0, pc=RESET_PC. The fetch restarts from RESET_PC and the stale ack does not load inst.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch stage,
// decoder and controller.
package cpu_pkg;

    localparam int CPU_ADDR_W = 16;
    localparam int CPU_INST_W = 18;

    localparam logic [CPU_ADDR_W-1:0] CPU_RESET_PC = 16'h0000;
    localparam logic [CPU_INST_W-1:0] NOP_INST = 18'h00000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_READY
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between
// the fetch stage (master) and instruction memory (slave).
interface fetch_mem_if #(
    parameter int ADDR_W = cpu_pkg::CPU_ADDR_W,
    parameter int INST_W = cpu_pkg::CPU_INST_W
);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ack;
    logic [INST_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_rd,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection and link value; the one place where
// PC arithmetic wraps modulo 2^ADDR_W.
module pc_next
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              JAddrSelect,
    output logic [ADDR_W-1:0] next_pc,
    output logic [ADDR_W-1:0] pc_plus1
);

    logic [ADDR_W-1:0] w_inc;

    assign w_inc    = pc + ADDR_W'(1);
    assign pc_plus1 = w_inc;
    assign next_pc  = JAddrSelect ? jump_target : w_inc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches one
// instruction at a time over the request/ack memory bus.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INST_W   = CPU_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              PC_inc,
    input  logic              JAddrSelect,
    input  logic [ADDR_W-1:0] jump_target,
    fetch_mem_if.master       mem,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              fetch_err
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rd;
    logic [INST_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              r_fetch_err;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_pc_plus1;

    pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc          (r_pc),
        .jump_target (jump_target),
        .JAddrSelect (JAddrSelect),
        .next_pc     (w_next_pc),
        .pc_plus1    (w_pc_plus1)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state      <= ST_IDLE;
            r_pc         <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_mem_rd     <= 1'b0;
            r_inst       <= INST_W'(NOP_INST);
            r_inst_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (PC_inc) r_fetch_err <= 1'b1;
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_pc;
                    r_state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (PC_inc) r_fetch_err <= 1'b1;
                    if (mem.mem_ack) begin
                        r_inst       <= mem.mem_rdata;
                        r_inst_valid <= 1'b1;
                        r_mem_rd     <= 1'b0;
                        r_state      <= ST_READY;
                    end
                end
                ST_READY: begin
                    // jump_target only matters on the retiring cycle
                    if (PC_inc) begin
                        r_pc         <= w_next_pc;
                        r_mem_addr   <= w_next_pc;
                        r_mem_rd     <= 1'b1;
                        r_inst_valid <= 1'b0;
                        r_state      <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_addr = r_mem_addr;
    assign mem.mem_rd   = r_mem_rd;
    assign inst         = r_inst;
    assign inst_valid   = r_inst_valid;
    assign pc           = r_pc;
    assign pc_plus1     = w_pc_plus1;
    assign fetch_err    = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a
// transaction-level model of the fetch protocol.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        PC_inc = 1'b0;
    logic        JAddrSelect = 1'b0;
    logic [15:0] jump_target = 16'h0000;
    logic [17:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        fetch_err;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_mem_if mem_if ();

    fetch_unit dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .PC_inc      (PC_inc),
        .JAddrSelect (JAddrSelect),
        .jump_target (jump_target),
        .mem         (mem_if.master),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pc_plus1    (pc_plus1),
        .fetch_err   (fetch_err)
    );

    always #5 CLK = ~CLK;

    // Model: "started" = one cycle has passed since reset
    // release; "pending" = a read is outstanding.
    bit          m_started = 0;
    bit          m_pending = 0;
    int unsigned m_pc = 0;
    int unsigned m_addr = 0;
    logic [17:0] m_inst = 18'h0;
    bit          m_valid = 0;
    bit          m_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit clr, input bit inc, input bit jsel,
                        input logic [15:0] jt, input bit ack,
                        input logic [17:0] rdata, input string tag);
        CLR = clr;
        PC_inc = inc;
        JAddrSelect = jsel;
        jump_target = jt;
        mem_if.mem_ack = ack;
        mem_if.mem_rdata = rdata;
        if (clr) begin
            m_started = 0; m_pending = 0; m_pc = 0; m_addr = 0;
            m_inst = 18'h0; m_valid = 0; m_err = 0;
        end else if (!m_started) begin
            if (inc) m_err = 1;
            m_started = 1;
            m_pending = 1;
            m_addr = m_pc;
        end else if (m_pending) begin
            if (inc) m_err = 1;
            if (ack) begin
                m_inst = rdata;
                m_valid = 1;
                m_pending = 0;
            end
        end else if (inc) begin
            m_pc = jsel ? int'(jt) : (m_pc + 1) % 65536;
            m_addr = m_pc;
            m_valid = 0;
            m_pending = 1;
        end
        @(posedge CLK);
        #1;
        chk({tag, ".pc"}, 32'(pc), m_pc);
        chk({tag, ".pc_plus1"}, 32'(pc_plus1), (m_pc + 1) % 65536);
        chk({tag, ".inst"}, 32'(inst), 32'(m_inst));
        chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(m_valid));
        chk({tag, ".mem_rd"}, 32'(mem_if.mem_rd), 32'(m_pending));
        chk({tag, ".fetch_err"}, 32'(fetch_err), 32'(m_err));
        if (m_pending)
            chk({tag, ".mem_addr"}, 32'(mem_if.mem_addr), m_addr);
    endtask

    task automatic idle(input string tag);
        tick(0, 0, 0, 16'h0, 0, 18'h0, tag);
    endtask

    task automatic ack(input logic [17:0] d, input string tag);
        tick(0, 0, 0, 16'h0, 1, d, tag);
    endtask

    task automatic jump(input logic [15:0] t, input string tag);
        tick(0, 1, 1, t, 0, 18'h0, tag);
    endtask

    initial begin
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = 18'h0;

        tick(1, 0, 0, 16'h0, 0, 18'h0, "rst0");
        tick(1, 1, 1, 16'h1234, 1, 18'h3ffff, "rst1");
        chk("rst.mem_addr", 32'(mem_if.mem_addr), 32'h0);
        idle("idle");
        chk("req.mem_addr", 32'(mem_if.mem_addr), 32'h0);
        ack(18'h12345, "first_ack");
        chk("first.inst", 32'(inst), 32'h12345);

        jump(16'h0004, "jmp4");
        ack(18'h00044, "ack4");
        tick(0, 1, 0, 16'hbeef, 0, 18'h0, "inc5");
        chk("inc5.addr", 32'(mem_if.mem_addr), 32'h5);
        idle("wait1");
        idle("wait2");
        idle("wait3");
        ack(18'h00055, "ack5");
        chk("ack5.valid", 32'(inst_valid), 32'h1);

        jump(16'h0200, "jmp200");
        chk("jmp200.addr", 32'(mem_if.mem_addr), 32'h200);
        ack(18'h22222, "ack200");
        for (int i = 0; i < 3; i++)
            tick(0, 0, 1, 16'h0777, 0, 18'h0, "jsel_only");
        tick(0, 0, 0, 16'h0, 1, 18'h1aaaa, "stray_ack");

        jump(16'hffff, "jmpffff");
        ack(18'h0ffff, "ackffff");
        chk("wrap.pc_plus1", 32'(pc_plus1), 32'h0);
        tick(0, 1, 0, 16'h0, 0, 18'h0, "wrap_inc");
        chk("wrap.pc", 32'(pc), 32'h0);

        tick(0, 1, 0, 16'h0, 0, 18'h0, "inc_in_req");
        tick(0, 1, 1, 16'h0900, 0, 18'h0, "inc_in_req2");
        ack(18'h10101, "ack_after_err");
        for (int i = 0; i < 4; i++) idle("err_sticky");

        for (int i = 0; i < 300; i++) begin
            logic [15:0] jt;
            logic [17:0] d;
            jt = 16'($urandom);
            d = 18'($urandom);
            tick(0, ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                 jt, $urandom_range(0, 2) == 0, d, "rand");
        end

        tick(1, 0, 0, 16'h0, 0, 18'h0, "rst2");
        idle("idle2");
        ack(18'h01234, "ack_r2");
        tick(0, 1, 0, 16'h0, 0, 18'h0, "inc_r2");
        idle("req_r2");
        tick(1, 1, 1, 16'h0abc, 0, 18'h0, "clr_in_req");
        tick(0, 0, 0, 16'h0, 1, 18'h3ffff, "late_ack");
        chk("late.inst", 32'(inst), 32'h0);
        chk("late.valid", 32'(inst_valid), 32'h0);
        ack(18'h2a5a5, "restart_ack");

        for (int i = 0; i < 200; i++) begin
            logic [15:0] jt;
            logic [17:0] d;
            jt = 16'($urandom);
            d = 18'($urandom);
            tick(($urandom_range(0, 40) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 1) == 1, jt,
                 $urandom_range(0, 2) == 0, d, "rand_clr");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
